// File: rtl/keypad_event_queue.sv
// Converts keypad controller keypresses into mole indices and queues them for the game logic.
// Each capture is followed by an active-low clear pulse that re-arms the keypad controller.
module keypad_event_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLEAR_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_key,
  input  logic [3:0]               key,
  output logic                     keypad_clear,
  output logic                     hit_valid,
  input  logic                     hit_ready,
  output logic [3:0]               hit_mole,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned RC_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CAPTURE  = 2'd1;
  localparam logic [1:0] REARM    = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  logic             v1, v2, v3;
  logic [3:0]       k1, k2;
  logic [1:0]       state, state_nxt;
  logic [RC_W-1:0]  rearm_cnt, rearm_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    count_nxt;
  logic [3:0]       head_nxt;
  logic [3:0]       mem [DEPTH];
  logic             rise, code_ok, full, pop, push, drop_full, drop_bad;
  logic [1:0]       col, row;
  logic [3:0]       mole;

  // Inputs come from another clock domain; v3 provides the edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      k1 <= 4'd0;
      k2 <= 4'd0;
    end else begin
      v1 <= valid_key;
      v2 <= v1;
      v3 <= v2;
      k1 <= key;
      k2 <= k1;
    end
  end

  assign rise    = v2 & ~v3;
  assign col     = k2[3:2];
  assign row     = k2[1:0];
  assign code_ok = (col != 2'd3) && (row != 2'd3);
  assign mole    = 4'(col) * 4'd3 + 4'(row);
  assign full    = (fifo_count == CW'(DEPTH));
  assign pop     = hit_valid & hit_ready;

  always_comb begin
    state_nxt = state;
    rearm_nxt = rearm_cnt;
    push      = 1'b0;
    drop_full = 1'b0;
    drop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = REARM;
        rearm_nxt = '0;
        if (!code_ok)          drop_bad  = 1'b1;
        else if (!full || pop) push      = 1'b1;
        else                   drop_full = 1'b1;
      end
      REARM: begin
        if (rearm_cnt == RC_W'(CLEAR_CYCLES - 1)) state_nxt = WAIT_LOW;
        else                                      rearm_nxt = rearm_cnt + RC_W'(1);
      end
      WAIT_LOW: begin
        if (!v2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next head is precomputed so hit_mole can be a plain register
  always_comb begin
    rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt = fifo_count + CW'(push) - CW'(pop);
    if (count_nxt == '0)                 head_nxt = hit_mole;
    else if (push && (wr_ptr == rd_nxt)) head_nxt = mole;
    else                                 head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rearm_cnt    <= '0;
      keypad_clear <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      hit_valid    <= 1'b0;
      hit_mole     <= 4'd0;
      overflow     <= 1'b0;
      drop_count   <= '0;
    end else begin
      state        <= state_nxt;
      rearm_cnt    <= rearm_nxt;
      keypad_clear <= (state_nxt != REARM);
      rd_ptr       <= rd_nxt;
      fifo_count   <= count_nxt;
      hit_valid    <= (count_nxt != '0);
      hit_mole     <= head_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (drop_full) overflow <= 1'b1;
      if ((drop_full || drop_bad) && (drop_count != '1))
        drop_count <= drop_count + CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mole;
  end

endmodule
